// File: rtl/obi_irq_pkg.sv
// Shared types and helpers for the OBI peripheral interrupt controller.
package obi_irq_pkg;

  localparam int unsigned NumSrcDefault = 5;
  localparam int unsigned MaxSrc        = 32;
  localparam int unsigned MaxIdWidth    = 5;

  typedef enum logic {
    RUN     = 1'b0,
    HOLDOFF = 1'b1
  } holdoff_state_e;

  // Register-file view of per-source configuration; edge_sel is 1 for edge-sticky.
  typedef struct packed {
    logic [NumSrcDefault-1:0] en;
    logic [NumSrcDefault-1:0] edge_sel;
  } irq_cfg_t;

  // Trailing-zero count: index of the lowest set bit, 0 when the vector is empty.
  function automatic logic [MaxIdWidth-1:0] lowest_set(input logic [MaxSrc-1:0] vec);
    logic [MaxIdWidth-1:0] idx;
    idx = '0;
    for (int i = MaxSrc - 1; i >= 0; i--) begin
      if (vec[i]) idx = MaxIdWidth'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/obi_irq_ctrl_if.sv
// Peripheral/register-file side of the interrupt controller.
interface obi_irq_ctrl_if #(
  parameter int unsigned NumSrc       = 5,
  parameter int unsigned IdWidth      = $clog2(NumSrc),
  parameter int unsigned HoldoffWidth = 8
);
  logic [NumSrc-1:0]       src_i;
  logic [NumSrc-1:0]       en_i;
  logic [NumSrc-1:0]       edge_i;
  logic [NumSrc-1:0]       clr_i;
  logic [HoldoffWidth-1:0] holdoff_i;
  logic [NumSrc-1:0]       pending_o;
  logic [IdWidth-1:0]      id_o;
  logic                    status_o;
  logic                    irq_o;
  logic                    irq_no;

  modport master (
    output src_i, en_i, edge_i, clr_i, holdoff_i,
    input  pending_o, id_o, status_o, irq_o, irq_no
  );

  modport slave (
    input  src_i, en_i, edge_i, clr_i, holdoff_i,
    output pending_o, id_o, status_o, irq_o, irq_no
  );
endinterface

// File: rtl/obi_irq_holdoff.sv
// Coalescing FSM: keeps the CPU line low for holdoff_i cycles after pending drains.
module obi_irq_holdoff
  import obi_irq_pkg::*;
#(
  parameter int unsigned HoldoffWidth = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    any_q,
  input  logic                    any_d,
  input  logic [HoldoffWidth-1:0] holdoff_i,
  output logic                    irq_gate
);

  holdoff_state_e          state_q;
  logic [HoldoffWidth-1:0] cnt_q;

  // holdoff_i is captured only on entry; later changes do not affect a running holdoff.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (any_q && !any_d && (holdoff_i != '0)) begin
            state_q <= HOLDOFF;
            cnt_q   <= holdoff_i;
          end
        end
        HOLDOFF: begin
          if (cnt_q == HoldoffWidth'(1)) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - HoldoffWidth'(1);
          end
        end
        default: begin
          state_q <= RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign irq_gate = (state_q == RUN);

endmodule

// File: rtl/obi_irq_ctrl.sv
// Interrupt controller for OBI peripherals: per-source level/edge pending,
// lowest-index priority ID, and a holdoff-gated CPU interrupt line.
module obi_irq_ctrl
  import obi_irq_pkg::*;
#(
  parameter int unsigned NumSrc       = 5,
  parameter int unsigned IdWidth      = $clog2(NumSrc),
  parameter int unsigned HoldoffWidth = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  obi_irq_ctrl_if.slave  bus
);

  logic [NumSrc-1:0] src_q;
  logic [NumSrc-1:0] pend_q;
  logic [NumSrc-1:0] pend_d;
  logic [NumSrc-1:0] rise;
  logic              any_q;
  logic              any_d;
  logic              irq_gate;

  // A rise coincident with a clear keeps an edge bit set; disabled sources never pend.
  always_comb begin
    rise   = bus.src_i & ~src_q;
    pend_d = bus.en_i & ( ( bus.edge_i & (rise | (pend_q & ~bus.clr_i)))
                        | (~bus.edge_i & bus.src_i & ~bus.clr_i));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_q  <= '0;
      pend_q <= '0;
    end else begin
      src_q  <= bus.src_i;
      pend_q <= pend_d;
    end
  end

  assign any_q = |pend_q;
  assign any_d = |pend_d;

  obi_irq_holdoff #(
    .HoldoffWidth (HoldoffWidth)
  ) u_holdoff (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .any_q     (any_q),
    .any_d     (any_d),
    .holdoff_i (bus.holdoff_i),
    .irq_gate  (irq_gate)
  );

  // ID and status follow pend_q directly; only irq_o is subject to holdoff.
  assign bus.pending_o = pend_q;
  assign bus.id_o      = IdWidth'(lowest_set(MaxSrc'(pend_q)));
  assign bus.status_o  = ~any_q;
  assign bus.irq_o     = any_q & irq_gate;
  assign bus.irq_no    = ~(any_q & irq_gate);

endmodule

// File: tb/tb_obi_irq_ctrl.sv
// Randomized and directed bench for obi_irq_ctrl against a cycle-level reference model.
module tb_obi_irq_ctrl;

  localparam int unsigned NumSrc       = 5;
  localparam int unsigned IdWidth      = 3;
  localparam int unsigned HoldoffWidth = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  obi_irq_ctrl_if #(.NumSrc(NumSrc), .IdWidth(IdWidth), .HoldoffWidth(HoldoffWidth)) bus ();

  obi_irq_ctrl #(.NumSrc(NumSrc), .IdWidth(IdWidth), .HoldoffWidth(HoldoffWidth)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: pending set, previous raw sources, remaining forced-low cycles.
  bit [NumSrc-1:0] m_pend;
  bit [NumSrc-1:0] m_prev;
  int              m_hold;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int m_id();
    int id = 0;
    for (int i = NumSrc - 1; i >= 0; i--) if (m_pend[i]) id = i;
    return id;
  endfunction

  function automatic bit m_irq();
    return (m_pend != '0) && (m_hold == 0);
  endfunction

  task automatic m_reset();
    m_pend = '0;
    m_prev = '0;
    m_hold = 0;
  endtask

  // Advance the model by one clock using the inputs as they stood at the edge.
  task automatic m_step();
    bit [NumSrc-1:0] nxt;
    for (int i = 0; i < NumSrc; i++) begin
      if (!bus.en_i[i])      nxt[i] = 1'b0;
      else if (bus.edge_i[i]) nxt[i] = (bus.src_i[i] && !m_prev[i]) || (m_pend[i] && !bus.clr_i[i]);
      else                    nxt[i] = bus.src_i[i] && !bus.clr_i[i];
    end
    if (m_hold > 0) m_hold--;
    else if ((m_pend != '0) && (nxt == '0) && (bus.holdoff_i != '0)) m_hold = int'(bus.holdoff_i);
    m_pend = nxt;
    m_prev = bus.src_i;
  endtask

  task automatic compare_all(input string ctx);
    check({ctx, "/pending"}, 32'(bus.pending_o), 32'(m_pend));
    check({ctx, "/id"},      32'(bus.id_o),      32'(m_id()));
    check({ctx, "/status"},  32'(bus.status_o),  32'(m_pend == '0));
    check({ctx, "/irq"},     32'(bus.irq_o),     32'(m_irq()));
    check({ctx, "/irq_n"},   32'(bus.irq_no),    32'(!m_irq()));
  endtask

  task automatic cycle(input string ctx);
    @(posedge clk);
    m_step();
    #1;
    compare_all(ctx);
  endtask

  task automatic drive(input logic [NumSrc-1:0] src, input logic [NumSrc-1:0] clr);
    bus.src_i = src;
    bus.clr_i = clr;
  endtask

  task automatic config_src(input logic [NumSrc-1:0] en, input logic [NumSrc-1:0] edg,
                            input logic [HoldoffWidth-1:0] hold);
    bus.en_i      = en;
    bus.edge_i    = edg;
    bus.holdoff_i = hold;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_reset();
    check("reset/pending", 32'(bus.pending_o), 32'h0);
    check("reset/id",      32'(bus.id_o),      32'h0);
    check("reset/status",  32'(bus.status_o),  32'h1);
    check("reset/irq",     32'(bus.irq_o),     32'h0);
    check("reset/irq_n",   32'(bus.irq_no),    32'h1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive('0, '0);
    config_src('0, '0, 8'd4);
    #2;
    do_reset();

    // Level source 2: pending one cycle after sampling, then a 4-cycle holdoff on drain.
    config_src(5'b00100, 5'b00000, 8'd4);
    drive(5'b00100, '0);
    cycle("lvl");
    check("lvl/id2",  32'(bus.id_o),  32'd2);
    check("lvl/irq1", 32'(bus.irq_o), 32'd1);
    cycle("lvl");
    drive('0, '0);
    for (int k = 0; k < 7; k++) begin
      cycle("lvl_drain");
      check("lvl_drain/irq0", 32'(bus.irq_o), 32'd0);
    end

    // Edge source 0 and level source 3: priority, clear, rise beating a clear.
    config_src(5'b01001, 5'b00001, 8'd4);
    drive(5'b01001, '0);
    cycle("edge");
    drive(5'b01000, '0);
    cycle("edge");
    check("edge/id0", 32'(bus.id_o), 32'd0);
    drive(5'b01000, 5'b00001);
    cycle("edge_clr");
    drive(5'b01000, '0);
    check("edge_clr/id3",  32'(bus.id_o),  32'd3);
    check("edge_clr/irq1", 32'(bus.irq_o), 32'd1);
    drive(5'b01001, '0);
    cycle("edge_rise");
    drive(5'b01000, '0);
    cycle("edge_rise");
    drive(5'b01001, 5'b00001);
    cycle("edge_rise_clr");
    check("edge_rise_clr/pend0", 32'(bus.pending_o[0]), 32'd1);
    drive(5'b00000, 5'b00001);
    for (int k = 0; k < 8; k++) begin
      cycle("edge_drain");
      drive('0, '0);
    end

    // Holdoff suppression: a new source during holdoff stays masked until it ends.
    config_src(5'b00110, 5'b00000, 8'd4);
    drive(5'b00100, '0);
    cycle("hold");
    drive('0, '0);
    cycle("hold_t");
    drive(5'b00010, '0);
    cycle("hold_t1");
    cycle("hold_t2");
    check("hold_t2/pend1",  32'(bus.pending_o), 32'b00010);
    check("hold_t2/status", 32'(bus.status_o),  32'd0);
    check("hold_t2/irq0",   32'(bus.irq_o),     32'd0);
    cycle("hold_t3");
    cycle("hold_t4");
    check("hold_t4/irq1", 32'(bus.irq_o), 32'd1);
    drive('0, '0);
    for (int k = 0; k < 6; k++) cycle("hold_drain");

    // Holdoff disabled: the line reasserts with no gap.
    config_src(5'b00110, 5'b00000, 8'd0);
    drive(5'b00100, '0);
    cycle("nohold");
    drive('0, '0);
    cycle("nohold");
    drive(5'b00010, '0);
    cycle("nohold");
    check("nohold/irq1", 32'(bus.irq_o), 32'd1);
    drive('0, '0);
    cycle("nohold");

    // Disable clears a sticky edge bit; re-enable without a rise leaves it clear.
    config_src(5'b10000, 5'b10000, 8'd4);
    drive(5'b10000, '0);
    cycle("dis");
    drive('0, '0);
    cycle("dis");
    bus.en_i = '0;
    cycle("dis_off");
    check("dis_off/pend4", 32'(bus.pending_o[4]), 32'd0);
    bus.en_i = 5'b10000;
    cycle("dis_on");
    check("dis_on/pend4", 32'(bus.pending_o[4]), 32'd0);
    for (int k = 0; k < 6; k++) cycle("dis_drain");

    // Randomized traffic with occasional config, clear and holdoff changes.
    config_src(5'b11111, 5'($urandom), 8'($urandom_range(0, 5)));
    for (int k = 0; k < 1500; k++) begin
      logic [NumSrc-1:0] flip;
      logic [NumSrc-1:0] clr;
      for (int i = 0; i < NumSrc; i++) begin
        flip[i] = ($urandom_range(0, 5) == 0);
        clr[i]  = ($urandom_range(0, 7) == 0);
      end
      drive(bus.src_i ^ flip, clr);
      if ($urandom_range(0, 31) == 0) bus.en_i      = 5'($urandom);
      if ($urandom_range(0, 63) == 0) bus.edge_i    = 5'($urandom);
      if ($urandom_range(0, 15) == 0) bus.holdoff_i = 8'($urandom_range(0, 6));
      if ((k % 100) == 50) bus.src_i = '0;
      cycle("rand");
    end

    // Asynchronous reset mid-run with every source high.
    config_src(5'b11111, 5'b00000, 8'd4);
    drive(5'b11111, '0);
    cycle("pre_rst");
    cycle("pre_rst");
    @(negedge clk);
    do_reset();
    cycle("post_rst");
    cycle("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute bound so a stuck clock or hang still ends the run.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/obi_irq_ctrl.md
Name: obi_irq_ctrl

Overview:
- Parametrised interrupt controller for OBI peripherals (UART, SPI, I2C) with NumSrc request lines.
- Each source has an enable and a mode: level-following or edge-sticky.
- Pending sources go through a fixed-priority encoder (lowest index wins) to give an ID and status; a holdoff (coalescing) FSM gates the CPU interrupt line.
- Sits between the peripheral datapath and its register file: the register file supplies configuration and clear strobes and reads pending, ID and status.

Parameters:
- NumSrc, 5, number of interrupt sources; must be >= 2.
- IdWidth, $clog2(NumSrc), width of the ID output.
- HoldoffWidth, 8, width of the holdoff counter and the holdoff_i input.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- src_i  in  NumSrc  raw interrupt conditions from the peripheral
- en_i  in  NumSrc  per-source enable (register-file IER equivalent)
- edge_i  in  NumSrc  per-source mode: 1 = edge-sticky, 0 = level
- clr_i  in  NumSrc  one-cycle clear strobes (status register read, data read, etc.)
- holdoff_i  in  HoldoffWidth  minimum irq-low cycles after pending drains; 0 disables
- pending_o  out  NumSrc  registered pending vector
- id_o  out  IdWidth  index of the highest-priority pending source
- status_o  out  1  1 = no pending source, 0 = pending present
- irq_o  out  1  active-high interrupt to the CPU
- irq_no  out  1  always ~irq_o

Behaviour:
- Reset (asynchronous, active-high) clears: src_q, pend_q, cnt_q; state = RUN.
  - Resulting outputs: pending_o=0, id_o=0, status_o=1, irq_o=0, irq_no=1.
- Edge detect: src_q registers src_i each cycle; rise[i] = src_i[i] & ~src_q[i].
- Next pending, per source i:
  - en_i[i]=0: pend_d[i]=0, regardless of mode or clear.
  - Level mode: pend_d[i] = src_i[i] & ~clr_i[i]. A clear suppresses the bit for one cycle only; it re-sets the next cycle if src_i is still high.
  - Edge mode: pend_d[i] = rise[i] | (pend_q[i] & ~clr_i[i]). A rise coincident with a clear wins (bit stays set).
- Latency:
  - pending_o reflects src_i one cycle after it is sampled.
  - An edge source is pending one cycle after the first cycle src_i is high.
- Priority encoder, combinational on pend_q:
  - id_o = lowest set index; id_o=0 when none is pending.
  - status_o = ~|pend_q.
  - id_o and status_o ignore the holdoff state.
- Holdoff FSM, states RUN and HOLDOFF:
  - RUN: irq_o = |pend_q.
  - RUN -> HOLDOFF when |pend_q=1, |pend_d=0 and holdoff_i!=0; cnt_q <= holdoff_i.
  - HOLDOFF: irq_o=0 even if sources are pending; cnt_q decrements each cycle.
  - HOLDOFF -> RUN on the cycle cnt_q==1; cnt_q <= 0.
  - irq_o is therefore low for exactly holdoff_i cycles after pending drains.
  - Pending bits keep setting during HOLDOFF; irq_o reasserts in the first RUN cycle if any bit is pending.
- holdoff_i is sampled only on RUN -> HOLDOFF; changing it mid-HOLDOFF has no effect. holdoff_i=0 never leaves RUN.
- Reset mid-HOLDOFF returns to RUN with cnt_q=0 immediately.
- en_i falling clears that pending bit on the next edge; this can trigger HOLDOFF like a normal clear.
- No combinational path from src_i to irq_o; the only combinational path is from pend_q and state to irq_o.

Decomposition:
- Package obi_irq_pkg holds:
  - holdoff_state_e (RUN=1'b0, HOLDOFF=1'b1);
  - typedef irq_cfg_t {en, edge} parametrised by NumSrc, used by register files.
- One natural sub-module: obi_irq_holdoff, containing the FSM plus counter. Inputs: any_q, any_d, holdoff_i. Output: irq_gate.
- Priority encoder: use the common_cells lzc (trailing-zero mode), not a new module.

Test Plan (NumSrc=5, holdoff_i=4 unless stated):
1. Reset: assert rst_i mid-run with src_i=5'b11111 -> same cycle pending_o=0, status_o=1, irq_o=0, irq_no=1.
2. Level source 2 (en=5'b00100, edge=0): src_i[2] high at cycle 0 -> pending_o=5'b00100, id_o=2, irq_o=1 from cycle 1; src_i[2] low -> irq_o=0 for 4 cycles, then stays 0.
3. Edge source 0 plus level source 3: src_i[0] pulse one cycle, src_i[3] held -> id_o=0. Then clr_i[0] -> id_o=3, irq_o stays 1. clr_i[0] with a coincident new rise on src 0 -> pending_o[0] stays 1.
4. Holdoff suppression: pending drains at cycle t, src 1 rises at t+1 -> pending_o[1]=1 and status_o=0 at t+2 but irq_o=0 until t+4, then 1 at t+4.
5. holdoff_i=0: pending drains -> irq_o falls and reasserts the very next cycle a source is pending, with no gap.
6. Disable: en_i[4] cleared while edge source 4 is pending -> pending_o[4]=0 next cycle. Re-enable without a new rise -> stays 0.
